// File: rtl/clk_div_ctrl_if.sv
// Handshake and status bundle for the clock-divider controller.
// master = the block that programs the divider, slave = clk_div_ctrl.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] cur_div;
  logic [15:0]      period_cnt;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, clk_out, tick, busy, cur_div, period_cnt
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, clk_out, tick, busy, cur_div, period_cnt
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with glitch-free ratio updates on period boundaries.
// Optional completed-period counter enabled by DIV_CTRL_PERIOD_CNT_EN.
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input logic           clk,
  input logic           reset,
  clk_div_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cur_div, load_div, pend_div, pend_n;
  logic [CNT_W-1:0] last, half, cnt_inc;
  logic             clk_q, clk_n, tick_q, tick_n, err_q, err_n;
  logic             acc, acc_ok, wrap, apply;

  assign last    = cur_div - 1'b1;
  assign half    = cur_div >> 1;
  assign cnt_inc = cnt + 1'b1;
  assign acc     = bus.cfg_valid & (state != PEND);
  assign acc_ok  = acc & (bus.cfg_div >= CNT_W'(2));
  assign wrap    = (state != IDLE) && (cnt == last);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pend_n   = pend_div;
    load_div = cur_div;
    apply    = 1'b0;
    clk_n    = clk_q;
    tick_n   = 1'b0;
    err_n    = acc & ~acc_ok;
    case (state)
      IDLE: begin
        clk_n = 1'b0;
        // Starting wins over an immediate load; the offered ratio waits for the first wrap.
        if (bus.en) begin
          state_n = RUN;
          cnt_n   = '0;
          clk_n   = 1'b1;
          tick_n  = 1'b1;
          if (acc_ok) begin
            pend_n  = bus.cfg_div;
            state_n = PEND;
          end
        end else if (acc_ok) begin
          load_div = bus.cfg_div;
          apply    = 1'b1;
        end
      end
      RUN, PEND: begin
        if (!wrap) begin
          cnt_n = cnt_inc;
          clk_n = (cnt_inc < half);
          if (state == RUN && acc_ok) begin
            pend_n  = bus.cfg_div;
            state_n = PEND;
          end
        end else begin
          cnt_n = '0;
          if (state == PEND) begin
            load_div = pend_div;
            apply    = 1'b1;
            state_n  = RUN;
          end else if (acc_ok) begin
            // Accepted on the wrap itself: the current period already used the old N.
            if (bus.en) begin
              pend_n  = bus.cfg_div;
              state_n = PEND;
            end else begin
              load_div = bus.cfg_div;
              apply    = 1'b1;
            end
          end
          if (bus.en) begin
            clk_n  = 1'b1;
            tick_n = 1'b1;
          end else begin
            clk_n   = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_div  <= CNT_W'(DEF_DIV);
      pend_div <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pend_div <= pend_n;
      clk_q    <= clk_n;
      tick_q   <= tick_n;
      err_q    <= err_n;
      if (apply) cur_div <= load_div;
    end
  end

`ifdef DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] pcnt;

  // A newly applied ratio restarts the count, even on the wrap that would bump it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      pcnt <= '0;
    else if (apply) pcnt <= '0;
    else if (wrap)  pcnt <= pcnt + 16'd1;
  end

  assign bus.period_cnt = pcnt;
`else
  assign bus.period_cnt = '0;
`endif

  assign bus.cfg_ready = (state != PEND);
  assign bus.cfg_err   = err_q;
  assign bus.clk_out   = clk_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = (state != IDLE);
  assign bus.cur_div   = cur_div;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a period/phase reference model.
module tb_clk_div_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clk_div_ctrl_if #(.CNT_W(8)) bus();
  clk_div_ctrl #(.CNT_W(8), .DEF_DIV(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // Reference: running flag, position within the period, ratio, ratio queue, period count.
  bit m_run, m_err;
  int m_pos, m_n, m_pc;
  int m_pend[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_run = 0; m_err = 0; m_pos = 0; m_n = 2; m_pc = 0;
    m_pend.delete();
  endfunction

  function automatic void m_step(input bit en, input bit v, input int div);
    bit acc, ok;
    acc   = v && !(m_run && m_pend.size() > 0);
    ok    = div >= 2;
    m_err = acc && !ok;
    if (!m_run) begin
      if (en) begin
        m_run = 1; m_pos = 0;
        if (acc && ok) m_pend.push_back(div);
      end else if (acc && ok) begin
        m_n = div; m_pc = 0;
      end
    end else if (m_pos == m_n - 1) begin
      m_pos = 0;
      m_pc  = (m_pc + 1) % 65536;
      if (m_pend.size() > 0) begin
        m_n = m_pend.pop_front(); m_pc = 0;
      end else if (acc && ok) begin
        if (en) m_pend.push_back(div);
        else begin m_n = div; m_pc = 0; end
      end
      if (!en) m_run = 0;
    end else begin
      m_pos++;
      if (acc && ok) m_pend.push_back(div);
    end
  endfunction

  task automatic check_all();
    int exp_pc;
`ifdef DIV_CTRL_PERIOD_CNT_EN
    exp_pc = m_pc;
`else
    exp_pc = 0;
`endif
    chk("clk_out",    bus.clk_out,    32'(m_run && (m_pos < m_n / 2)));
    chk("tick",       bus.tick,       32'(m_run && m_pos == 0));
    chk("busy",       bus.busy,       32'(m_run));
    chk("cfg_ready",  bus.cfg_ready,  32'(!(m_run && m_pend.size() > 0)));
    chk("cfg_err",    bus.cfg_err,    32'(m_err));
    chk("cur_div",    bus.cur_div,    32'(m_n));
    chk("period_cnt", bus.period_cnt, 32'(exp_pc));
  endtask

  // One clock: drive at the negedge, step model at posedge, compare at next negedge.
  task automatic cyc(input bit en, input bit v, input int div);
    logic [7:0] d;
    d             = div[7:0];
    bus.en        = en;
    bus.cfg_valid = v;
    bus.cfg_div   = d;
    @(posedge clk);
    m_step(en, v, div);
    @(negedge clk);
    check_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clk"},   bus.clk_out,    0);
    chk({tag, "_tick"},  bus.tick,       0);
    chk({tag, "_err"},   bus.cfg_err,    0);
    chk({tag, "_rdy"},   bus.cfg_ready,  1);
    chk({tag, "_busy"},  bus.busy,       0);
    chk({tag, "_div"},   bus.cur_div,    2);
    chk({tag, "_pcnt"},  bus.period_cnt, 0);
  endtask

  // Asynchronous reset in the middle of the low clock phase.
  task automatic async_rst();
    #2;
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    #1;
    m_reset();
    chk_reset_vals("arst");
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    m_reset();
    @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;

    // N=2 run, then stop with en dropped at cnt=0
    repeat (7) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("t1_tail_busy", bus.busy, 1);
    cyc(0, 0, 0);
    chk("t1_idle", bus.busy, 0);

    // N=3 loaded while idle
    cyc(0, 1, 3);
    repeat (6) cyc(1, 0, 0);
    chk("t2_div", bus.cur_div, 3);

    // Running N=4, offer 6 at cnt=1
    repeat (3) cyc(0, 0, 0);
    cyc(0, 1, 4);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 6);
    chk("t3_rdy0", bus.cfg_ready, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("t3_div6", bus.cur_div, 6);
    chk("t3_rdy1", bus.cfg_ready, 1);
    repeat (6) cyc(1, 0, 0);

    // Invalid ratios
    cyc(1, 1, 1);
    chk("t4_err1", bus.cfg_err, 1);
    cyc(1, 1, 0);
    chk("t4_err0", bus.cfg_err, 1);
    chk("t4_div", bus.cur_div, 6);
    cyc(1, 0, 0);
    chk("t4_clr", bus.cfg_err, 0);

    // Reset mid-period with N=5, then restart at default ratio
    repeat (6) cyc(0, 0, 0);
    cyc(0, 1, 5);
    repeat (3) cyc(1, 0, 0);
    async_rst();
    repeat (4) cyc(1, 0, 0);

    // Period counter: 10 periods at N=2, then apply 4
    async_rst();
    repeat (21) cyc(1, 0, 0);
`ifdef DIV_CTRL_PERIOD_CNT_EN
    chk("t6_pc10", bus.period_cnt, 10);
`else
    chk("t6_pc0", bus.period_cnt, 0);
`endif
    cyc(1, 1, 4);
    cyc(1, 0, 0);
    chk("t6_div4", bus.cur_div, 4);
    chk("t6_pclr", bus.period_cnt, 0);

    // Maximum ratio
    repeat (4) cyc(0, 0, 0);
    cyc(0, 1, 255);
    repeat (260) cyc(1, 0, 0);
    chk("max_div", bus.cur_div, 255);

    // Randomized traffic
    begin
      bit en_r;
      en_r = 1;
      for (int i = 0; i < 3000; i++) begin
        int r, div;
        bit v;
        if ($urandom_range(0, 19) == 0) en_r = ~en_r;
        v = ($urandom_range(0, 4) == 0);
        r = $urandom_range(0, 99);
        if (r < 10)      div = $urandom_range(0, 1);
        else if (r < 15) div = $urandom_range(250, 255);
        else             div = $urandom_range(2, 9);
        if ($urandom_range(0, 299) == 0) async_rst();
        else cyc(en_r, v, div);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
